membrane_integrator: RTL and testbench
======================================

Name: membrane_integrator

Overview:
- Closes the Hodgkin-Huxley loop: consumes the ionic currents produced by the per-channel current blocks (sodium, potassium, leak) and the external stimulus, then integrates membrane potential V by one forward-Euler step per request.
- The registered V output feeds back to the current and gating blocks.
- Adds threshold-crossing spike detection and a spike counter.
- All signals are signed 16-bit Q8.8: V in mV, dt in ms, currents in uA/cm^2; C_m = 1.

Parameters:
V_REST, 16'shBF00 (-65.0 mV), reset and initial value of V
V_THRESH, 16'sh0000 (0.0 mV), spike threshold
TIMEOUT, 255, max cycles in COLLECT before abort
COUNT_W, 16, spike counter width

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
step_start  in  1  one-cycle request to begin an integration step
dt  in  16  signed Q8.8 timestep, sampled on accepted step_start
i_ext  in  16  signed Q8.8 stimulus current, sampled on accepted step_start
i_na / i_na_valid  in  16/1  sodium current and strobe
i_k / i_k_valid  in  16/1  potassium current and strobe
i_leak / i_leak_valid  in  16/1  leak current and strobe
v_out  out  16  signed Q8.8 membrane potential (registered)
v_valid  out  1  one-cycle pulse: v_out updated
busy  out  1  high in any state other than IDLE
spike  out  1  one-cycle pulse on upward threshold crossing
spike_count  out  COUNT_W  spikes since reset, saturating
sat  out  1  sticky: V update saturated
timeout  out  1  one-cycle pulse on COLLECT abort

Behaviour:
- Reset (synchronous, rst high at posedge): v_out=V_REST, state=IDLE, all pulse outputs=0, spike_count=0, sat=0, got-flags cleared. Reset in any state, including mid-step, aborts the step.
- FSM IDLE -> COLLECT -> SUM -> MULT -> UPDATE -> IDLE.
- IDLE:
  - step_start=1: latch dt and i_ext; clear got_na, got_k, got_leak; clear timeout counter; go to COLLECT.
  - Current valids are ignored in IDLE.
- COLLECT:
  - Each *_valid latches its current and sets its got-flag. Strobes may be simultaneous or in any order.
  - A repeated strobe overwrites the latched value (last wins).
  - The final strobe is captured in the same cycle as the transition: when all three flags will be set after this edge, go to SUM.
  - The timeout counter increments each COLLECT cycle. At count==TIMEOUT-1 without completion: pulse timeout, leave v_out unchanged, go to IDLE.
- step_start while busy is ignored (no queueing).
- SUM: register 18-bit signed sum = i_ext - i_na - i_k - i_leak. This cannot overflow.
- MULT: register 34-bit product = dt * sum.
- UPDATE:
  - dV = product >>> 8 (arithmetic shift, truncate toward -inf).
  - v_new = v_out + dV, computed in 35 bits, then saturated to [-32768, 32767]; set sat if clipped.
  - Register v_out=v_new and pulse v_valid.
  - If v_out < V_THRESH and v_new >= V_THRESH: pulse spike in the same cycle as v_valid, and increment spike_count (holds at all-ones).
- Latency: if the last current strobe is sampled at edge k, v_out and v_valid are visible after edge k+3. A new step_start is accepted on the cycle after v_valid.
- busy is combinational from state; v_valid, spike and timeout are registered.

Decomposition:
- Package hh_fixed_pkg:
  - Q8.8 frac-bit constant (8)
  - V_REST and V_THRESH defaults
  - FSM state enum
  - sat16 function (35-bit to 16-bit clamp), shared with the current blocks
- One natural sub-module: spike_detector. Inputs: v_prev, v_new, update strobe. Outputs: spike pulse and saturating counter.

Test Plan:
- Basic step: i_ext=16'h0A00 (10.0), all ionic currents 0 (strobed together one cycle after step_start), dt=16'h0010 (0.0625) -> v_out goes 16'hBF00 -> 16'hBFA0 exactly 3 edges after the strobe; one v_valid pulse; spike=0.
- Out-of-order and duplicate strobes: i_leak, then i_na=16'h0100, then i_na=16'h0200, then i_k, with i_ext=0 and dt=16'h0100 -> dV uses i_na=16'h0200, giving v_out=16'hBD00 when i_k and i_leak are 0.
- Spike: V_REST=-16, i_ext=16'h0100, dt=16'h0100 -> v_out=16'h00F0, spike=1, spike_count=1. An identical second step gives v_out=16'h01F0, spike=0, count stays 1.
- Saturation: V_REST=16'h7F00, i_ext=16'h7FFF, dt=16'h0100 -> v_out=16'h7FFF, sat=1 and stays 1 on later non-saturating steps.
- Timeout: step_start, then strobe only i_na and i_k -> timeout pulse after TIMEOUT cycles, v_out unchanged, v_valid never pulses, busy drops, and the next step_start is accepted.
- Reset mid-step: rst in COLLECT (and separately in MULT) after a prior spike -> next cycle v_out=V_REST, busy=0, spike_count=0, sat=0; a late current strobe after reset has no effect.

Source files
------------

// File: rtl/hh_fixed_pkg.sv
// Shared Q8.8 fixed-point definitions for the Hodgkin-Huxley datapath blocks.
package hh_fixed_pkg;

  localparam int unsigned FRAC_BITS = 8;

  localparam logic signed [15:0] V_REST_DEFAULT   = 16'shBF00;
  localparam logic signed [15:0] V_THRESH_DEFAULT = 16'sh0000;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_SUM     = 3'd2,
    ST_MULT    = 3'd3,
    ST_UPDATE  = 3'd4
  } state_e;

  function automatic logic signed [15:0] sat16(input logic signed [34:0] x);
    if (x > 35'sd32767) begin
      return 16'sh7FFF;
    end else if (x < -35'sd32768) begin
      return 16'sh8000;
    end else begin
      return x[15:0];
    end
  endfunction

endpackage

// File: rtl/spike_detector.sv
// Upward threshold-crossing detector with a saturating spike counter.
module spike_detector
  import hh_fixed_pkg::*;
#(
  parameter logic signed [15:0] V_THRESH = V_THRESH_DEFAULT,
  parameter int                 COUNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      upd_i,
  input  logic signed [15:0]        v_prev_i,
  input  logic signed [15:0]        v_new_i,
  output logic                      spike_o,
  output logic [COUNT_W-1:0]        count_o
);

  logic               cross_s;
  logic               spike_q;
  logic [COUNT_W-1:0] count_q;
  logic [COUNT_W-1:0] count_d;

  assign cross_s = upd_i && (v_prev_i < V_THRESH) && (v_new_i >= V_THRESH);

  always_comb begin
    count_d = count_q;
    if (cross_s && (count_q != {COUNT_W{1'b1}})) begin
      count_d = count_q + {{(COUNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      spike_q <= 1'b0;
      count_q <= {COUNT_W{1'b0}};
    end else begin
      spike_q <= cross_s;
      count_q <= count_d;
    end
  end

  assign spike_o = spike_q;
  assign count_o = count_q;

endmodule

// File: rtl/membrane_integrator.sv
// Forward-Euler membrane potential integrator: collects the ionic currents,
// then sums, multiplies by dt and updates V with saturation and spike detection.
module membrane_integrator
  import hh_fixed_pkg::*;
#(
  parameter logic signed [15:0] V_REST   = V_REST_DEFAULT,
  parameter logic signed [15:0] V_THRESH = V_THRESH_DEFAULT,
  parameter int                 TIMEOUT  = 255,
  parameter int                 COUNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                step_start,
  input  logic signed [15:0]  dt,
  input  logic signed [15:0]  i_ext,
  input  logic signed [15:0]  i_na,
  input  logic                i_na_valid,
  input  logic signed [15:0]  i_k,
  input  logic                i_k_valid,
  input  logic signed [15:0]  i_leak,
  input  logic                i_leak_valid,
  output logic signed [15:0]  v_out,
  output logic                v_valid,
  output logic                busy,
  output logic                spike,
  output logic [COUNT_W-1:0]  spike_count,
  output logic                sat,
  output logic                timeout
);

  localparam int TCNT_W = $clog2(TIMEOUT + 1);

  state_e              state_q, state_d;
  logic signed [15:0]  dt_q, dt_d, iext_q, iext_d;
  logic signed [15:0]  ina_q, ina_d, ik_q, ik_d, ileak_q, ileak_d;
  logic                got_na_q, got_na_d, got_k_q, got_k_d, got_leak_q, got_leak_d;
  logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
  logic signed [17:0]  sum_q, sum_d;
  logic signed [33:0]  prod_q, prod_d;
  logic signed [15:0]  v_q, v_d;
  logic                v_valid_q, v_valid_d, timeout_q, timeout_d, sat_q, sat_d;

  logic                all_s;
  logic signed [33:0]  dv_s;
  logic signed [34:0]  v_wide_s;
  logic signed [15:0]  v_new_s;
  logic                clip_s;

  assign all_s = (got_na_q | i_na_valid) & (got_k_q | i_k_valid) & (got_leak_q | i_leak_valid);

  // Arithmetic shift floors toward -inf; 35-bit sum keeps the clamp exact.
  assign dv_s     = prod_q >>> FRAC_BITS;
  assign v_wide_s = 35'(v_q) + 35'(dv_s);
  assign v_new_s  = sat16(v_wide_s);
  assign clip_s   = (v_wide_s != 35'(v_new_s));

  always_comb begin
    state_d    = state_q;
    dt_d       = dt_q;
    iext_d     = iext_q;
    ina_d      = ina_q;
    ik_d       = ik_q;
    ileak_d    = ileak_q;
    got_na_d   = got_na_q;
    got_k_d    = got_k_q;
    got_leak_d = got_leak_q;
    tcnt_d     = tcnt_q;
    sum_d      = sum_q;
    prod_d     = prod_q;
    v_d        = v_q;
    sat_d      = sat_q;
    v_valid_d  = 1'b0;
    timeout_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (step_start) begin
          dt_d       = dt;
          iext_d     = i_ext;
          got_na_d   = 1'b0;
          got_k_d    = 1'b0;
          got_leak_d = 1'b0;
          tcnt_d     = {TCNT_W{1'b0}};
          state_d    = ST_COLLECT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COLLECT: begin
        if (i_na_valid) begin
          ina_d    = i_na;
          got_na_d = 1'b1;
        end else begin
          ina_d = ina_q;
        end
        if (i_k_valid) begin
          ik_d    = i_k;
          got_k_d = 1'b1;
        end else begin
          ik_d = ik_q;
        end
        if (i_leak_valid) begin
          ileak_d    = i_leak;
          got_leak_d = 1'b1;
        end else begin
          ileak_d = ileak_q;
        end
        tcnt_d = tcnt_q + {{(TCNT_W-1){1'b0}}, 1'b1};
        // Completion wins over an expiring timeout in the same cycle.
        if (all_s) begin
          state_d = ST_SUM;
        end else if (tcnt_q == TCNT_W'(TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          state_d = ST_COLLECT;
        end
      end
      ST_SUM: begin
        sum_d   = 18'(iext_q) - 18'(ina_q) - 18'(ik_q) - 18'(ileak_q);
        state_d = ST_MULT;
      end
      ST_MULT: begin
        prod_d  = 34'(dt_q) * 34'(sum_q);
        state_d = ST_UPDATE;
      end
      ST_UPDATE: begin
        v_d       = v_new_s;
        v_valid_d = 1'b1;
        if (clip_s) begin
          sat_d = 1'b1;
        end else begin
          sat_d = sat_q;
        end
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      dt_q       <= 16'sh0000;
      iext_q     <= 16'sh0000;
      ina_q      <= 16'sh0000;
      ik_q       <= 16'sh0000;
      ileak_q    <= 16'sh0000;
      got_na_q   <= 1'b0;
      got_k_q    <= 1'b0;
      got_leak_q <= 1'b0;
      tcnt_q     <= {TCNT_W{1'b0}};
      sum_q      <= 18'sh00000;
      prod_q     <= 34'sh0;
      v_q        <= V_REST;
      sat_q      <= 1'b0;
      v_valid_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      dt_q       <= dt_d;
      iext_q     <= iext_d;
      ina_q      <= ina_d;
      ik_q       <= ik_d;
      ileak_q    <= ileak_d;
      got_na_q   <= got_na_d;
      got_k_q    <= got_k_d;
      got_leak_q <= got_leak_d;
      tcnt_q     <= tcnt_d;
      sum_q      <= sum_d;
      prod_q     <= prod_d;
      v_q        <= v_d;
      sat_q      <= sat_d;
      v_valid_q  <= v_valid_d;
      timeout_q  <= timeout_d;
    end
  end

  spike_detector #(
    .V_THRESH (V_THRESH),
    .COUNT_W  (COUNT_W)
  ) u_spike (
    .clk      (clk),
    .rst      (rst),
    .upd_i    (state_q == ST_UPDATE),
    .v_prev_i (v_q),
    .v_new_i  (v_new_s),
    .spike_o  (spike),
    .count_o  (spike_count)
  );

  assign v_out   = v_q;
  assign v_valid = v_valid_q;
  assign busy    = (state_q != ST_IDLE);
  assign sat     = sat_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_membrane_integrator.sv
// Directed bench: three integrators with different rest potentials share one stimulus.
module tb_membrane_integrator;

  logic               clk = 1'b0;
  logic               rst;
  logic               step_start;
  logic signed [15:0] dt, i_ext, i_na, i_k, i_leak;
  logic               i_na_valid, i_k_valid, i_leak_valid;

  logic [15:0] v_out [3];
  logic        v_valid [3];
  logic        busy [3];
  logic        spike [3];
  logic [15:0] spike_count [3];
  logic        sat [3];
  logic        timeout [3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  membrane_integrator dut0 (
    .clk(clk), .rst(rst), .step_start(step_start), .dt(dt), .i_ext(i_ext),
    .i_na(i_na), .i_na_valid(i_na_valid), .i_k(i_k), .i_k_valid(i_k_valid),
    .i_leak(i_leak), .i_leak_valid(i_leak_valid),
    .v_out(v_out[0]), .v_valid(v_valid[0]), .busy(busy[0]), .spike(spike[0]),
    .spike_count(spike_count[0]), .sat(sat[0]), .timeout(timeout[0])
  );

  membrane_integrator #(.V_REST(16'shFFF0)) dut1 (
    .clk(clk), .rst(rst), .step_start(step_start), .dt(dt), .i_ext(i_ext),
    .i_na(i_na), .i_na_valid(i_na_valid), .i_k(i_k), .i_k_valid(i_k_valid),
    .i_leak(i_leak), .i_leak_valid(i_leak_valid),
    .v_out(v_out[1]), .v_valid(v_valid[1]), .busy(busy[1]), .spike(spike[1]),
    .spike_count(spike_count[1]), .sat(sat[1]), .timeout(timeout[1])
  );

  membrane_integrator #(.V_REST(16'sh7F00)) dut2 (
    .clk(clk), .rst(rst), .step_start(step_start), .dt(dt), .i_ext(i_ext),
    .i_na(i_na), .i_na_valid(i_na_valid), .i_k(i_k), .i_k_valid(i_k_valid),
    .i_leak(i_leak), .i_leak_valid(i_leak_valid),
    .v_out(v_out[2]), .v_valid(v_valid[2]), .busy(busy[2]), .spike(spike[2]),
    .spike_count(spike_count[2]), .sat(sat[2]), .timeout(timeout[2])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic start(input logic [15:0] dt_v, input logic [15:0] iext_v);
    step_start = 1'b1;
    dt         = dt_v;
    i_ext      = iext_v;
    tick();
    step_start = 1'b0;
  endtask

  task automatic strobe(input logic nv, input logic [15:0] na, input logic kv, input logic [15:0] k,
                        input logic lv, input logic [15:0] l);
    i_na_valid = nv;   i_na = na;
    i_k_valid = kv;    i_k = k;
    i_leak_valid = lv; i_leak = l;
    tick();
    i_na_valid = 1'b0;
    i_k_valid = 1'b0;
    i_leak_valid = 1'b0;
  endtask

  initial begin
    int n;
    int vv;
    rst = 1'b1; step_start = 1'b0; dt = 16'h0000; i_ext = 16'h0000;
    i_na = 16'h0000; i_k = 16'h0000; i_leak = 16'h0000;
    i_na_valid = 1'b0; i_k_valid = 1'b0; i_leak_valid = 1'b0;
    tick();
    tick();
    chk("rst_v", v_out[0], 32'h0000BF00);
    chk("rst_busy", busy[0], 32'd0);
    chk("rst_vvalid", v_valid[0], 32'd0);
    chk("rst_spike", spike[0], 32'd0);
    chk("rst_count", spike_count[0], 32'd0);
    chk("rst_sat", sat[0], 32'd0);
    chk("rst_timeout", timeout[0], 32'd0);
    rst = 1'b0;

    // Basic step: 10.0 * 0.0625 = 0.625 mV -> 0xA0
    start(16'h0010, 16'h0A00);
    chk("basic_busy", busy[0], 32'd1);
    strobe(1'b1, 16'h0000, 1'b1, 16'h0000, 1'b1, 16'h0000);
    tick();
    chk("basic_k1_valid", v_valid[0], 32'd0);
    tick();
    chk("basic_k2_valid", v_valid[0], 32'd0);
    chk("basic_k2_v", v_out[0], 32'h0000BF00);
    tick();
    chk("basic_v", v_out[0], 32'h0000BFA0);
    chk("basic_valid", v_valid[0], 32'd1);
    chk("basic_spike", spike[0], 32'd0);
    tick();
    chk("basic_valid_pulse", v_valid[0], 32'd0);
    chk("basic_idle", busy[0], 32'd0);

    // Out-of-order, duplicate strobes; step_start while busy must be ignored
    do_reset();
    start(16'h0100, 16'h0000);
    step_start = 1'b1; dt = 16'h4000; i_ext = 16'h4000;
    strobe(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0000);
    step_start = 1'b0;
    strobe(1'b1, 16'h0100, 1'b0, 16'h0000, 1'b0, 16'h0000);
    strobe(1'b1, 16'h0200, 1'b0, 16'h0000, 1'b0, 16'h0000);
    chk("ooo_busy", busy[0], 32'd1);
    strobe(1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 16'h0000);
    tick(); tick(); tick();
    chk("ooo_v", v_out[0], 32'h0000BD00);
    chk("ooo_valid", v_valid[0], 32'd1);

    // Spike on the -16 rest instance; the 0x7F00 instance clips
    do_reset();
    start(16'h0100, 16'h0100);
    strobe(1'b1, 16'h0000, 1'b1, 16'h0000, 1'b1, 16'h0000);
    tick(); tick(); tick();
    chk("spk1_v", v_out[1], 32'h000000F0);
    chk("spk1_spike", spike[1], 32'd1);
    chk("spk1_count", spike_count[1], 32'd1);
    chk("spk1_v_a", v_out[0], 32'h0000C000);
    chk("spk1_spike_a", spike[0], 32'd0);
    chk("spk1_sat_c", sat[2], 32'd1);
    chk("spk1_v_c", v_out[2], 32'h00007FFF);
    tick();
    chk("spk1_pulse", spike[1], 32'd0);
    start(16'h0100, 16'h0100);
    strobe(1'b1, 16'h0000, 1'b1, 16'h0000, 1'b1, 16'h0000);
    tick(); tick(); tick();
    chk("spk2_v", v_out[1], 32'h000001F0);
    chk("spk2_spike", spike[1], 32'd0);
    chk("spk2_count", spike_count[1], 32'd1);

    // Reset while in COLLECT, then a late strobe
    start(16'h0100, 16'h0100);
    chk("rc_busy", busy[1], 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rc_v", v_out[1], 32'h0000FFF0);
    chk("rc_busy_after", busy[1], 32'd0);
    chk("rc_count", spike_count[1], 32'd0);
    chk("rc_sat", sat[2], 32'd0);
    vv = 0;
    strobe(1'b1, 16'h0100, 1'b1, 16'h0100, 1'b1, 16'h0100);
    for (int i = 0; i < 5; i++) begin
      if (v_valid[1] || busy[1]) vv++;
      tick();
    end
    chk("rc_late_activity", vv, 32'd0);
    chk("rc_late_v", v_out[1], 32'h0000FFF0);

    // Reset while in MULT after another spike
    start(16'h0100, 16'h0100);
    strobe(1'b1, 16'h0000, 1'b1, 16'h0000, 1'b1, 16'h0000);
    tick(); tick(); tick();
    chk("rm_pre_count", spike_count[1], 32'd1);
    start(16'h0100, 16'h0100);
    strobe(1'b1, 16'h0000, 1'b1, 16'h0000, 1'b1, 16'h0000);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rm_v", v_out[1], 32'h0000FFF0);
    chk("rm_busy", busy[1], 32'd0);
    chk("rm_count", spike_count[1], 32'd0);
    vv = 0;
    strobe(1'b1, 16'h0100, 1'b1, 16'h0100, 1'b1, 16'h0100);
    for (int i = 0; i < 5; i++) begin
      if (v_valid[1]) vv++;
      tick();
    end
    chk("rm_late_valid", vv, 32'd0);
    chk("rm_late_v", v_out[1], 32'h0000FFF0);

    // Saturation is sticky across later non-clipping steps
    do_reset();
    start(16'h0100, 16'h7FFF);
    strobe(1'b1, 16'h0000, 1'b1, 16'h0000, 1'b1, 16'h0000);
    tick(); tick(); tick();
    chk("sat_v", v_out[2], 32'h00007FFF);
    chk("sat_flag", sat[2], 32'd1);
    chk("sat_none_a", sat[0], 32'd0);
    start(16'h0100, 16'hFF00);
    strobe(1'b1, 16'h0000, 1'b1, 16'h0000, 1'b1, 16'h0000);
    tick(); tick(); tick();
    chk("sat2_v", v_out[2], 32'h00007EFF);
    chk("sat2_sticky", sat[2], 32'd1);

    // Timeout: leak never arrives
    do_reset();
    start(16'h0100, 16'h0100);
    strobe(1'b1, 16'h0100, 1'b1, 16'h0100, 1'b0, 16'h0000);
    n = 1;
    vv = 0;
    while (timeout[0] !== 1'b1 && n < 400) begin
      tick();
      n++;
      if (v_valid[0]) vv++;
    end
    chk("to_cycles", n, 32'd255);
    chk("to_pulse", timeout[0], 32'd1);
    chk("to_busy", busy[0], 32'd0);
    chk("to_v", v_out[0], 32'h0000BF00);
    chk("to_no_valid", vv, 32'd0);
    tick();
    chk("to_pulse_end", timeout[0], 32'd0);
    start(16'h0100, 16'h0000);
    chk("to_restart", busy[0], 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
